systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
Source-side driver for the ArrSize x ArrSize output-stationary MAC array; it produces the in_x and in_y edge streams and the clear that the array's processing elements consume.
- Per job, it reads k_len row-vectors from operand buffers A and B.
- It skews lane i by i cycles so operands meet diagonally inside the array.
- It drives zeros whenever a lane carries no valid data, because the PEs accumulate every cycle.
- It pulses done in the first cycle in which every PE accumulator holds its final value.

Parameters:
DataWidth, 8, width of one operand element
ArrSize, 4, array rows/columns; number of lanes on each edge
KLenWidth, 16, width of k_len and rd_addr

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  job request pulse; sampled only in IDLE
k_len  input  KLenWidth  reduction length; latched on accepted start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; all accumulators final
rd_en  output  1  buffer read strobe (A and B shared)
rd_addr  output  KLenWidth  buffer row address
rd_data_a  input  ArrSize*DataWidth  A row; valid the cycle after rd_en; lane i = [i*DataWidth +: DataWidth]
rd_data_b  input  ArrSize*DataWidth  B row; same timing and lane order as rd_data_a
pe_clear  output  1  broadcast clear to all PE accumulators
x_out  output  ArrSize*DataWidth  row-edge operands; lane i drives in_x of row i, column 0
y_out  output  ArrSize*DataWidth  column-edge operands; lane j drives in_y of column j, row 0

Behaviour:
Reset:
- rst_n low asynchronously forces IDLE, clears all counters and skew registers, and zeros every output.
- Reset mid-job abandons the job; no done is issued.

FSM: IDLE -> CLEAR -> FEED -> FLUSH -> DONE -> IDLE.
- IDLE: start=1 latches k_len and moves to CLEAR. start is ignored in every other state.
- CLEAR: one cycle with pe_clear=1. Next state is FEED, or FLUSH if k_len==0.
- FEED: exactly k_len cycles. rd_en=1 and rd_addr counts 0..k_len-1, one per cycle, with no gaps.
- FLUSH: exactly 2*ArrSize cycles. rd_en=0.
- DONE: one cycle with done=1, then IDLE. done is the only completion indication.

Datapath:
- Returned rows are captured the cycle after rd_en, together with a per-row valid bit.
- Lane i (0..ArrSize-1) of the captured A and B rows passes through i skew registers plus one output register.
- Element read at cycle t appears on x_out/y_out lane i at cycle t+2+i.
- Each skew stage carries its valid bit. Any lane whose valid bit is 0 drives 0, so a zero operand contributes nothing to the accumulators.

Timing:
- With the last FEED cycle at T, PE(i,j) sees its last operand pair at T+2+i+j.
- Accumulator PE(ArrSize-1, ArrSize-1) is final at T+2*ArrSize+1, which is the DONE cycle.
- For k_len==0, with the CLEAR cycle at C, FLUSH covers C+1..C+2*ArrSize and done occurs at C+2*ArrSize+1.

Other rules:
- No arithmetic on operands; values pass through bit-exact regardless of signedness.
- k_len up to 2^KLenWidth-1 is supported. rd_addr never wraps within a job.
- Back-to-back jobs: start in the cycle after done is accepted.

Optional Feature:
FEEDER_PERF_CNT_EN
- Defined:
  - Adds output perf_cycles[31:0], the number of cycles from the accepted start through done inclusive for the most recent completed job, updated in the DONE cycle.
  - Adds output perf_jobs[31:0], the number of completed jobs; it saturates at all-ones.
  - Both outputs reset to 0, and both are unchanged by a job aborted by reset.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
Reset then idle (ArrSize=4):
- Stimulus: hold rst_n low, release; no start for 20 cycles.
- Required: all outputs 0 throughout.

k_len=3, A rows = {lane i = 10*r+i}, B rows = {lane j = 100+10*r+j}:
- Required: pe_clear high for exactly 1 cycle.
- Required: rd_addr = 0,1,2.
- Required: x_out lane 2 = 0, 0, 0, 0, 2, 12, 22, 0 starting at the first FEED cycle.
- Required: done at T+9.
- Required: a behavioural 4x4 array model yields acc(i,j) = sum over r of A[r][i]*B[r][j].

k_len=0:
- Required: sequence CLEAR, 8 FLUSH cycles, done; rd_en never high; x_out and y_out stay 0.

Start ignored while busy:
- Stimulus: second start, with k_len=5, issued during FEED of a k_len=3 job.
- Required: exactly 3 reads and a single done.

Reset mid-FEED:
- Stimulus: rst_n low at the 2nd FEED cycle.
- Required: outputs zero immediately; no done; a subsequent job completes normally.

FEEDER_PERF_CNT_EN with two jobs of k_len=3:
- Required: perf_cycles = 14 and perf_jobs = 2.

Source files
------------

// File: rtl/systolic_skew_feeder_if.sv
// rtl/systolic_skew_feeder_if.sv - control, operand-buffer and array-edge signals of the skew feeder
// FEEDER_PERF_CNT_EN adds the perf_cycles/perf_jobs counter outputs.
interface systolic_skew_feeder_if #(
  parameter int DataWidth = 8,
  parameter int ArrSize   = 4,
  parameter int KLenWidth = 16
);
  logic                         start;
  logic [KLenWidth-1:0]         k_len;
  logic                         busy;
  logic                         done;
  logic                         rd_en;
  logic [KLenWidth-1:0]         rd_addr;
  logic [ArrSize*DataWidth-1:0] rd_data_a;
  logic [ArrSize*DataWidth-1:0] rd_data_b;
  logic                         pe_clear;
  logic [ArrSize*DataWidth-1:0] x_out;
  logic [ArrSize*DataWidth-1:0] y_out;

`ifdef FEEDER_PERF_CNT_EN
  logic [31:0]                  perf_cycles;
  logic [31:0]                  perf_jobs;

  modport slave (
    input  start, k_len, rd_data_a, rd_data_b,
    output busy, done, rd_en, rd_addr, pe_clear, x_out, y_out,
    output perf_cycles, perf_jobs
  );

  modport master (
    output start, k_len, rd_data_a, rd_data_b,
    input  busy, done, rd_en, rd_addr, pe_clear, x_out, y_out,
    input  perf_cycles, perf_jobs
  );
`else
  modport slave (
    input  start, k_len, rd_data_a, rd_data_b,
    output busy, done, rd_en, rd_addr, pe_clear, x_out, y_out
  );

  modport master (
    output start, k_len, rd_data_a, rd_data_b,
    input  busy, done, rd_en, rd_addr, pe_clear, x_out, y_out
  );
`endif
endinterface

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - skews A/B buffer rows onto the edges of an output-stationary MAC array
// FEEDER_PERF_CNT_EN adds per-job cycle and completed-job counters.
module systolic_skew_feeder #(
  parameter int DataWidth = 8,
  parameter int ArrSize   = 4,
  parameter int KLenWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  systolic_skew_feeder_if.slave bus
);

  localparam int FlushLen = 2 * ArrSize;
  localparam int FlushW   = $clog2(FlushLen);
  localparam logic [FlushW-1:0] FlushLast = FlushW'(FlushLen - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [KLenWidth-1:0]   r_k_len;
  logic [KLenWidth-1:0]   r_addr;
  logic [FlushW-1:0]      r_flush_cnt;
  logic                   r_row_vld;

  logic                   w_accept;
  logic                   w_feed_last;
  logic                   w_flush_last;
  logic                   w_busy;
  logic                   w_done;
  logic                   w_rd_en;
  logic                   w_pe_clear;
  logic [ArrSize*DataWidth-1:0] w_x_out;
  logic [ArrSize*DataWidth-1:0] w_y_out;

  assign w_accept     = (r_state == S_IDLE) && bus.start;
  assign w_feed_last  = (r_addr == (r_k_len - KLenWidth'(1)));
  assign w_flush_last = (r_flush_cnt == FlushLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_busy     = 1'b1;
    w_done     = 1'b0;
    w_rd_en    = 1'b0;
    w_pe_clear = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        w_pe_clear = 1'b1;
        w_next     = (r_k_len == '0) ? S_FLUSH : S_FEED;
      end
      S_FEED: begin
        w_rd_en = 1'b1;
        if (w_feed_last) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (w_flush_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  // r_addr returns to 0 when FEED ends, so rd_addr reads 0 outside FEED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k_len     <= '0;
      r_addr      <= '0;
      r_flush_cnt <= '0;
      r_row_vld   <= 1'b0;
    end else begin
      r_row_vld <= w_rd_en;
      if (w_accept) r_k_len <= bus.k_len;
      if (r_state == S_FEED) begin
        r_addr <= w_feed_last ? '0 : r_addr + KLenWidth'(1);
      end
      if (r_state == S_FLUSH) begin
        r_flush_cnt <= w_flush_last ? '0 : r_flush_cnt + FlushW'(1);
      end
    end
  end

  // Stage 0 captures the returned row; lane i then adds i skew stages.
  for (genvar gi = 0; gi < ArrSize; gi++) begin : g_lane
    logic [DataWidth-1:0] r_a_pipe [0:gi];
    logic [DataWidth-1:0] r_b_pipe [0:gi];
    logic [gi:0]          r_vld_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= gi; s++) begin
          r_a_pipe[s] <= '0;
          r_b_pipe[s] <= '0;
        end
        r_vld_pipe <= '0;
      end else begin
        r_a_pipe[0]   <= bus.rd_data_a[gi*DataWidth +: DataWidth];
        r_b_pipe[0]   <= bus.rd_data_b[gi*DataWidth +: DataWidth];
        r_vld_pipe[0] <= r_row_vld;
        for (int s = 1; s <= gi; s++) begin
          r_a_pipe[s]   <= r_a_pipe[s-1];
          r_b_pipe[s]   <= r_b_pipe[s-1];
          r_vld_pipe[s] <= r_vld_pipe[s-1];
        end
      end
    end

    // PEs accumulate every cycle, so an empty slot must present zero.
    assign w_x_out[gi*DataWidth +: DataWidth] = r_vld_pipe[gi] ? r_a_pipe[gi] : '0;
    assign w_y_out[gi*DataWidth +: DataWidth] = r_vld_pipe[gi] ? r_b_pipe[gi] : '0;
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.rd_en    = w_rd_en;
  assign bus.rd_addr  = r_addr;
  assign bus.pe_clear = w_pe_clear;
  assign bus.x_out    = w_x_out;
  assign bus.y_out    = w_y_out;

`ifdef FEEDER_PERF_CNT_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_jobs;

  // r_cyc_cnt already counts the start cycle, hence the +1 in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt     <= '0;
      r_perf_cycles <= '0;
      r_perf_jobs   <= '0;
    end else begin
      if (w_accept) begin
        r_cyc_cnt <= 32'd1;
      end else if (r_state != S_IDLE) begin
        r_cyc_cnt <= r_cyc_cnt + 32'd1;
      end
      if (r_state == S_DONE) begin
        r_perf_cycles <= r_cyc_cnt + 32'd1;
        if (r_perf_jobs != '1) r_perf_jobs <= r_perf_jobs + 32'd1;
      end
    end
  end

  assign bus.perf_cycles = r_perf_cycles;
  assign bus.perf_jobs   = r_perf_jobs;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - scoreboard bench for systolic_skew_feeder with a 4x4 PE array model
module tb_systolic_skew_feeder;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int KW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.DataWidth(DW), .ArrSize(N), .KLenWidth(KW)) bus ();

  systolic_skew_feeder #(.DataWidth(DW), .ArrSize(N), .KLenWidth(KW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int             c;
    logic [DW-1:0]  v;
  } lane_ev_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int job_base = 0;
  int done_seen = 0;
  int busy_from = 1;
  int busy_to = 0;

  lane_ev_t            qx [N][$];
  lane_ev_t            qy [N][$];
  int                  q_addr [$];
  int                  q_clear [$];
  int                  q_done [$];
  logic [N*N*32-1:0]   q_acc [$];

  logic [31:0]   acc [N][N];
  logic [DW-1:0] xp [N][N];
  logic [DW-1:0] yp [N][N];

  logic          s_en;
  logic [KW-1:0] s_addr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] a_elem(input int base, input int r, input int i);
    return DW'(base + 10*r + i);
  endfunction

  function automatic logic [DW-1:0] b_elem(input int base, input int r, input int j);
    return DW'(100 + base + 10*r + j);
  endfunction

  // Buffer model: one-cycle read latency; 0xEE on idle cycles exposes missing lane masking.
  initial begin : mem_model
    bus.rd_data_a = '0;
    bus.rd_data_b = '0;
    forever begin
      @(negedge clk);
      s_en   = bus.rd_en;
      s_addr = bus.rd_addr;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        bus.rd_data_a[i*DW +: DW] = s_en ? a_elem(job_base, int'(s_addr), i) : 8'hEE;
        bus.rd_data_b[i*DW +: DW] = s_en ? b_elem(job_base, int'(s_addr), i) : 8'hEE;
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc[i][j] = '0;
        xp[i][j]  = '0;
        yp[i][j]  = '0;
      end
  end

  always @(negedge clk) begin : monitor
    lane_ev_t e;
    logic [N*N*32-1:0] ea;
    int c;
    c = cyc;
    for (int i = 0; i < N; i++) begin
      if (qx[i].size() > 0 && qx[i][0].c == c) begin
        e = qx[i].pop_front();
        chk($sformatf("x_out[%0d]", i), bus.x_out[i*DW +: DW], e.v);
      end else begin
        chk($sformatf("x_out[%0d]_zero", i), bus.x_out[i*DW +: DW], 0);
      end
      if (qy[i].size() > 0 && qy[i][0].c == c) begin
        e = qy[i].pop_front();
        chk($sformatf("y_out[%0d]", i), bus.y_out[i*DW +: DW], e.v);
      end else begin
        chk($sformatf("y_out[%0d]_zero", i), bus.y_out[i*DW +: DW], 0);
      end
    end
    chk("busy", bus.busy, (c >= busy_from && c <= busy_to));
    if (bus.rd_en) begin
      if (q_addr.size() == 0) chk("rd_en_unexpected", 1, 0);
      else chk("rd_addr", bus.rd_addr, q_addr.pop_front());
    end else begin
      chk("rd_addr_idle", bus.rd_addr, 0);
    end
    if (bus.pe_clear) begin
      if (q_clear.size() == 0) chk("pe_clear_unexpected", 1, 0);
      else chk("pe_clear_cycle", c, q_clear.pop_front());
    end
    if (bus.done) begin
      if (q_done.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        chk("done_cycle", c, q_done.pop_front());
        ea = q_acc.pop_front();
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            chk($sformatf("acc(%0d,%0d)", i, j), acc[i][j], ea[(i*N+j)*32 +: 32]);
      end
      done_seen++;
    end
    // Array model: x moves right, y moves down, every PE accumulates each cycle.
    for (int i = 0; i < N; i++)
      for (int j = N-1; j > 0; j--) xp[i][j] = xp[i][j-1];
    for (int j = 0; j < N; j++)
      for (int i = N-1; i > 0; i--) yp[i][j] = yp[i-1][j];
    for (int i = 0; i < N; i++) begin
      xp[i][0] = bus.x_out[i*DW +: DW];
      yp[0][i] = bus.y_out[i*DW +: DW];
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        acc[i][j] = bus.pe_clear ? 32'd0 : acc[i][j] + 32'(xp[i][j]) * 32'(yp[i][j]);
  end

  task automatic flush_expect();
    for (int i = 0; i < N; i++) begin
      qx[i].delete();
      qy[i].delete();
    end
    q_addr.delete();
    q_clear.delete();
    q_done.delete();
    q_acc.delete();
    busy_from = 1;
    busy_to   = 0;
  endtask

  task automatic check_drained();
    int pend;
    pend = q_addr.size() + q_clear.size() + q_done.size() + q_acc.size();
    for (int i = 0; i < N; i++) pend += qx[i].size() + qy[i].size();
    chk("scoreboard_drained", pend, 0);
  endtask

  // Call at posedge+1; start is accepted at the end of the current cycle s.
  task automatic run_job(input int k, input int base, input bit inject);
    int s;
    int f;
    int seen0;
    bit got;
    logic [31:0] sum;
    logic [N*N*32-1:0] ea;
    lane_ev_t e;
    s = cyc;
    f = s + 2;
    job_base = base;
    q_clear.push_back(s + 1);
    for (int r = 0; r < k; r++) q_addr.push_back(r);
    for (int i = 0; i < N; i++)
      for (int r = 0; r < k; r++) begin
        e.c = f + r + 2 + i;
        e.v = a_elem(base, r, i);
        qx[i].push_back(e);
        e.v = b_elem(base, r, i);
        qy[i].push_back(e);
      end
    ea = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int r = 0; r < k; r++) sum += 32'(a_elem(base, r, i)) * 32'(b_elem(base, r, j));
        ea[(i*N+j)*32 +: 32] = sum;
      end
    q_acc.push_back(ea);
    q_done.push_back(s + k + 10);
    busy_from = s + 1;
    busy_to   = s + k + 10;
    seen0 = done_seen;
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.k_len = '1;
    if (inject) begin
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.k_len = KW'(5);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    got = 1'b0;
    for (int t = 0; t < k + 40 && !got; t++) begin
      @(posedge clk); #1;
      if (done_seen != seen0) got = 1'b1;
    end
    chk("done_within_budget", got, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stimulus
    int s;
    bus.start = 1'b0;
    bus.k_len = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_rd_en", bus.rd_en, 0);
    chk("reset_pe_clear", bus.pe_clear, 0);
    chk("reset_x_out", bus.x_out, 0);
    chk("reset_y_out", bus.y_out, 0);
`ifdef FEEDER_PERF_CNT_EN
    chk("reset_perf_cycles", bus.perf_cycles, 0);
    chk("reset_perf_jobs", bus.perf_jobs, 0);
`endif
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    run_job(3, 0, 1'b0);
    check_drained();
    chk("acc00_hand", acc[0][0], 3500);
    chk("acc33_hand", acc[3][3], 4607);

    run_job(0, 0, 1'b0);
    check_drained();

    run_job(3, 50, 1'b1);
    check_drained();

    // Reset during the second FEED cycle abandons the job.
    s = cyc;
    job_base = 0;
    q_clear.push_back(s + 1);
    q_addr.push_back(0);
    busy_from = s + 1;
    busy_to   = s + 2;
    bus.start = 1'b1;
    bus.k_len = KW'(3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush_expect();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_rd_en", bus.rd_en, 0);
    chk("abort_rd_addr", bus.rd_addr, 0);
    chk("abort_pe_clear", bus.pe_clear, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_x_out", bus.x_out, 0);
    chk("abort_y_out", bus.y_out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;

    run_job(3, 20, 1'b0);
    check_drained();
    run_job(3, 0, 1'b0);
    check_drained();
`ifdef FEEDER_PERF_CNT_EN
    chk("perf_cycles", bus.perf_cycles, 14);
    chk("perf_jobs", bus.perf_jobs, 2);
`endif
    repeat (5) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
